id_ex_pipe_reg: RTL and testbench
=================================

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; parameter CNTW, default 16, bubble-counter width.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_pc, id_data1, id_data2, id_imm  in  XLEN each  ID-stage PC, register-file read data (rs1 and rs2), and immediate.
- id_rd  in  5  ID destination register.
- id_we, id_memr, id_memw  in  1 each  ID register-write, memory-read and memory-write controls.
- id_alu_op  in  5  ID ALU operation.
- id_valid  in  1  ID holds a real instruction.
- fwd_data1sel, fwd_data2sel  in  2 each  forwarding selects: 00 = ID, 01 = EX, 10 = MEM.
- bubble, stall  in  1 each  hazard-unit bubble and stall requests.
- flush  in  1  branch/jump redirect from EX.
- ex_fwd_result, mem_fwd_result  in  XLEN each  EX ALU result and MEM-stage write-back value.
- ex_pc, ex_data1, ex_data2, ex_imm  out  XLEN each  registered EX operands.
- ex_rd  out  5; ex_we, ex_memr, ex_memw  out  1 each; ex_alu_op  out  5; ex_valid  out  1.
- bubble_count  out  CNTW  number of bubbles inserted.

Function
REQ-003 SHALL form operand1 combinationally:
- 00 selects id_data1; 01 selects ex_fwd_result; 10 selects mem_fwd_result.
- 11 selects id_data1 (illegal encoding, treated as 00).
REQ-004 SHALL form operand2 identically from fwd_data2sel and id_data2.
REQ-005 SHALL update all ex_* registers on the rising clk edge with one-cycle latency, using the priority in REQ-006 to REQ-009.
REQ-006 flush=1 SHALL load a NOP: ex_valid, ex_we, ex_memr and ex_memw = 0; ex_rd = 0; ex_alu_op = 0; ex_pc, ex_data1, ex_data2 and ex_imm = 0.
REQ-007 When flush=0 and bubble=1, the block SHALL load the same NOP regardless of stall.
REQ-008 When flush=0, bubble=0 and stall=1, the block SHALL hold every ex_* register unchanged.
REQ-009 Otherwise the block SHALL load the forwarded operands and all id_* fields.
- id_valid=0 SHALL force ex_we, ex_memr and ex_memw to 0 in the loaded value.
REQ-010 SHALL sample the forwarded operand in the same cycle as the select; no forwarding value SHALL be registered separately.
REQ-011 SHALL increment bubble_count by 1 on each edge where bubble=1 and flush=0.
- The counter saturates at all-ones and never wraps.
- Flush-generated NOPs are not counted.
REQ-012 Simultaneous flush and bubble SHALL yield exactly one NOP and no count increment.
REQ-013 Control outputs SHALL never carry X after reset, even when data inputs are X.

Reset
REQ-014 rst_n=0 SHALL immediately clear every ex_* output and bubble_count to 0, without waiting for clk.
REQ-015 Deassertion of rst_n SHALL take effect at the first rising clk edge after release.
- Assertion of rst_n mid-operation SHALL discard any held (stalled) content.

Structure
REQ-016 SHALL place the following in the shared CPU package:
- the forwarding-select encodings (FWD_ID, FWD_EX, FWD_MEM);
- the ALU-op width constant;
- the NOP control bundle value.
REQ-017 SHALL instantiate one sub-module, fwd_mux, twice: a 3:1 XLEN-wide operand mux with default-to-ID behaviour.
REQ-018 SHALL contain no other sub-modules.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Forward EX: fwd_data1sel=01, ex_fwd_result=0x0000_00AA, id_data1=0x11 -> after one edge, ex_data1=0x0000_00AA.
- Forward MEM and illegal select: fwd_data2sel=10, mem_fwd_result=0xDEAD_BEEF -> ex_data2=0xDEAD_BEEF; fwd_data2sel=11, id_data2=0x5 -> ex_data2=0x5.
- Load-use: bubble=1 and stall=1 with id_we=1 and id_rd=7 -> ex_valid=0, ex_we=0, ex_rd=0, and bubble_count increments from 0 to 1.
- Stall hold: load pc=0x100, then stall=1 and bubble=0 for 3 cycles while id_pc=0x104 -> ex_pc stays 0x100 for all 3 cycles, then becomes 0x104.
- Flush priority: flush=1 and bubble=1 together -> NOP loaded, bubble_count unchanged. Saturation: preload the counter to 0xFFFF, apply bubble -> count stays 0xFFFF.
- Async reset: assert rst_n=0 mid-cycle while ex_valid=1 -> ex_valid=0 and bubble_count=0 before the next clk edge.

Source files
------------

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared CPU definitions for the ID/EX pipeline boundary.
//   fwd_sel_e  : forwarding-select encodings (ID, EX, MEM)
//   ALU_OP_W   : ALU operation field width
//   ex_ctrl_t  : control bundle carried from ID into EX
//   NOP_CTRL   : control bundle value of an injected bubble/flush NOP
package id_ex_pipe_reg_pkg;

  typedef enum logic [1:0] {
    FWD_ID  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int unsigned ALU_OP_W = 5;
  localparam int unsigned REG_W    = 5;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic                memr;
    logic                memw;
    logic [REG_W-1:0]    rd;
    logic [ALU_OP_W-1:0] alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/id_ex_pipe_reg_fwd_mux.sv
// fwd_mux: 3:1 operand forwarding mux.
//   sel_i      : forwarding select (00 ID, 01 EX, 10 MEM, 11 -> ID)
//   id_data_i  : register-file read value from ID
//   ex_data_i  : EX-stage ALU result
//   mem_data_i : MEM-stage write-back value
//   data_o     : selected operand
module fwd_mux
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      sel_i,
  input  logic [XLEN-1:0] id_data_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic [XLEN-1:0] mem_data_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = id_data_i;
    case (sel_i)
      FWD_EX:  data_o = ex_data_i;
      FWD_MEM: data_o = mem_data_i;
      default: data_o = id_data_i;  // 00 and illegal 11
    endcase
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with operand forwarding,
// bubble/stall/flush handling and a saturating bubble counter.
//   clk, rst_n                 : clock, async active-low reset
//   id_*                       : ID-stage instruction fields
//   fwd_data1sel/fwd_data2sel  : operand forwarding selects
//   ex_fwd_result/mem_fwd_result : forwarding sources
//   bubble, stall, flush       : hazard controls (flush > bubble > stall)
//   ex_*                       : registered EX-stage fields
//   bubble_count               : saturating count of bubbles inserted
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [XLEN-1:0]     id_data1,
  input  logic [XLEN-1:0]     id_data2,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_we,
  input  logic                id_memr,
  input  logic                id_memw,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_valid,
  input  logic [1:0]          fwd_data1sel,
  input  logic [1:0]          fwd_data2sel,
  input  logic                bubble,
  input  logic                stall,
  input  logic                flush,
  input  logic [XLEN-1:0]     ex_fwd_result,
  input  logic [XLEN-1:0]     mem_fwd_result,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_data1,
  output logic [XLEN-1:0]     ex_data2,
  output logic [XLEN-1:0]     ex_imm,
  output logic [REG_W-1:0]    ex_rd,
  output logic                ex_we,
  output logic                ex_memr,
  output logic                ex_memw,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_valid,
  output logic [CNTW-1:0]     bubble_count
);

  logic [XLEN-1:0] op1, op2;

  fwd_mux #(.XLEN(XLEN)) u_fwd1 (
    .sel_i      (fwd_data1sel),
    .id_data_i  (id_data1),
    .ex_data_i  (ex_fwd_result),
    .mem_data_i (mem_fwd_result),
    .data_o     (op1)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd2 (
    .sel_i      (fwd_data2sel),
    .id_data_i  (id_data2),
    .ex_data_i  (ex_fwd_result),
    .mem_data_i (mem_fwd_result),
    .data_o     (op2)
  );

  ex_ctrl_t        ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d, d1_q, d1_d, d2_q, d2_d, imm_q, imm_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    ctrl_d = ctrl_q;
    pc_d   = pc_q;
    d1_d   = d1_q;
    d2_d   = d2_q;
    imm_d  = imm_q;
    cnt_d  = cnt_q;

    if (flush || bubble) begin
      ctrl_d = NOP_CTRL;
      pc_d   = '0;
      d1_d   = '0;
      d2_d   = '0;
      imm_d  = '0;
    end else if (!stall) begin
      ctrl_d.valid  = id_valid;
      // Side-effecting controls are qualified so an invalid slot can never write.
      ctrl_d.we     = id_we   & id_valid;
      ctrl_d.memr   = id_memr & id_valid;
      ctrl_d.memw   = id_memw & id_valid;
      ctrl_d.rd     = id_rd;
      ctrl_d.alu_op = id_alu_op;
      pc_d          = id_pc;
      d1_d          = op1;
      d2_d          = op2;
      imm_d         = id_imm;
    end

    // Only hazard bubbles are counted; a coincident flush owns the NOP.
    if (bubble && !flush && (cnt_q != '1))
      cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= NOP_CTRL;
      pc_q   <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
      imm_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pc_q   <= pc_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      imm_q  <= imm_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_pc        = pc_q;
  assign ex_data1     = d1_q;
  assign ex_data2     = d2_q;
  assign ex_imm       = imm_q;
  assign ex_rd        = ctrl_q.rd;
  assign ex_we        = ctrl_q.we;
  assign ex_memr      = ctrl_q.memr;
  assign ex_memw      = ctrl_q.memw;
  assign ex_alu_op    = ctrl_q.alu_op;
  assign ex_valid     = ctrl_q.valid;
  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: one task per scenario, inline checks.
module tb_id_ex_pipe_reg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] id_pc, id_data1, id_data2, id_imm;
  logic [4:0]      id_rd, id_alu_op;
  logic            id_we, id_memr, id_memw, id_valid;
  logic [1:0]      fwd_data1sel, fwd_data2sel;
  logic            bubble, stall, flush;
  logic [XLEN-1:0] ex_fwd_result, mem_fwd_result;
  logic [XLEN-1:0] ex_pc, ex_data1, ex_data2, ex_imm;
  logic [4:0]      ex_rd, ex_alu_op;
  logic            ex_we, ex_memr, ex_memw, ex_valid;
  logic [CNTW-1:0] bubble_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_pc(id_pc), .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
    .id_rd(id_rd), .id_we(id_we), .id_memr(id_memr), .id_memw(id_memw),
    .id_alu_op(id_alu_op), .id_valid(id_valid),
    .fwd_data1sel(fwd_data1sel), .fwd_data2sel(fwd_data2sel),
    .bubble(bubble), .stall(stall), .flush(flush),
    .ex_fwd_result(ex_fwd_result), .mem_fwd_result(mem_fwd_result),
    .ex_pc(ex_pc), .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_memr(ex_memr), .ex_memw(ex_memw),
    .ex_alu_op(ex_alu_op), .ex_valid(ex_valid), .bubble_count(bubble_count)
  );

  task automatic drive_idle();
    id_pc = '0; id_data1 = '0; id_data2 = '0; id_imm = '0;
    id_rd = '0; id_we = 1'b0; id_memr = 1'b0; id_memw = 1'b0;
    id_alu_op = '0; id_valid = 1'b0;
    fwd_data1sel = 2'b00; fwd_data2sel = 2'b00;
    bubble = 1'b0; stall = 1'b0; flush = 1'b0;
    ex_fwd_result = '0; mem_fwd_result = '0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    #12;
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
    checks++;
    if (bubble_count !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp 0000", bubble_count); end
    checks++;
    if (ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", ex_pc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fwd_ex();
    id_valid = 1'b1; id_data1 = 32'h11; fwd_data1sel = 2'b01;
    ex_fwd_result = 32'h0000_00AA; id_alu_op = 5'd3; id_imm = 32'h44;
    step();
    checks++;
    if (ex_data1 !== 32'h0000_00AA) begin errors++; $display("FAIL fwd_ex got %h exp 000000aa", ex_data1); end
    checks++;
    if (ex_valid !== 1'b1 || ex_alu_op !== 5'd3 || ex_imm !== 32'h44) begin
      errors++; $display("FAIL fwd_ex_fields got v=%b op=%0d imm=%h exp v=1 op=3 imm=44", ex_valid, ex_alu_op, ex_imm);
    end
    fwd_data1sel = 2'b00;
    step();
    checks++;
    if (ex_data1 !== 32'h11) begin errors++; $display("FAIL fwd_id got %h exp 11", ex_data1); end
  endtask

  task automatic test_fwd_mem();
    fwd_data2sel = 2'b10; mem_fwd_result = 32'hDEAD_BEEF; id_data2 = 32'h5;
    step();
    checks++;
    if (ex_data2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_mem got %h exp deadbeef", ex_data2); end
    fwd_data2sel = 2'b11;
    step();
    checks++;
    if (ex_data2 !== 32'h5) begin errors++; $display("FAIL fwd_illegal got %h exp 5", ex_data2); end
    fwd_data2sel = 2'b00;
  endtask

  task automatic test_valid_gate();
    id_valid = 1'b0; id_we = 1'b1; id_memr = 1'b1; id_memw = 1'b1; id_rd = 5'd9;
    id_data1 = 'x;
    step();
    checks++;
    if (ex_we !== 1'b0 || ex_memr !== 1'b0 || ex_memw !== 1'b0) begin
      errors++; $display("FAIL valid_gate got we=%b r=%b w=%b exp 000", ex_we, ex_memr, ex_memw);
    end
    checks++;
    if (ex_rd !== 5'd9 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL valid_gate_rd got rd=%0d v=%b exp rd=9 v=0", ex_rd, ex_valid);
    end
    id_valid = 1'b1; id_memr = 1'b1; id_memw = 1'b0;
    step();
    checks++;
    if (ex_we !== 1'b1 || ex_memr !== 1'b1 || ex_memw !== 1'b0 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL ctrl_load got we=%b r=%b w=%b v=%b exp 1101", ex_we, ex_memr, ex_memw, ex_valid);
    end
    id_data1 = 32'h11; id_memr = 1'b0;
  endtask

  task automatic test_load_use();
    id_valid = 1'b1; id_we = 1'b1; id_rd = 5'd7; bubble = 1'b1; stall = 1'b1;
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_we !== 1'b0 || ex_rd !== 5'd0) begin
      errors++; $display("FAIL load_use got v=%b we=%b rd=%0d exp v=0 we=0 rd=0", ex_valid, ex_we, ex_rd);
    end
    checks++;
    if (bubble_count !== 16'd1) begin errors++; $display("FAIL load_use_count got %0d exp 1", bubble_count); end
    checks++;
    if (ex_data1 !== 32'h0 || ex_pc !== 32'h0) begin
      errors++; $display("FAIL load_use_data got d1=%h pc=%h exp 0", ex_data1, ex_pc);
    end
    bubble = 1'b0; stall = 1'b0;
  endtask

  task automatic test_stall_hold();
    id_pc = 32'h100;
    step();
    checks++;
    if (ex_pc !== 32'h100) begin errors++; $display("FAIL stall_load got %h exp 100", ex_pc); end
    id_pc = 32'h104; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ex_pc !== 32'h100 || ex_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got pc=%h v=%b exp pc=100 v=1", i, ex_pc, ex_valid);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (ex_pc !== 32'h104) begin errors++; $display("FAIL stall_release got %h exp 104", ex_pc); end
    checks++;
    if (bubble_count !== 16'd1) begin errors++; $display("FAIL stall_count got %0d exp 1", bubble_count); end
  endtask

  task automatic test_flush_priority();
    flush = 1'b1; bubble = 1'b1; id_pc = 32'h200;
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_we !== 1'b0 || ex_pc !== 32'h0 || ex_alu_op !== 5'd0) begin
      errors++; $display("FAIL flush_nop got v=%b we=%b pc=%h op=%0d exp 0", ex_valid, ex_we, ex_pc, ex_alu_op);
    end
    checks++;
    if (bubble_count !== 16'd1) begin errors++; $display("FAIL flush_count got %0d exp 1", bubble_count); end
    flush = 1'b0; bubble = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    bubble = 1'b1;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    checks++;
    if (bubble_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp ffff", bubble_count); end
    step();
    checks++;
    if (bubble_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", bubble_count); end
    bubble = 1'b0;
  endtask

  task automatic test_async_reset();
    id_valid = 1'b1; id_pc = 32'h300; stall = 1'b0;
    step();
    checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %b exp 1", ex_valid); end
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || bubble_count !== 16'h0 || ex_pc !== 32'h0) begin
      errors++; $display("FAIL areset got v=%b cnt=%h pc=%h exp 0", ex_valid, bubble_count, ex_pc);
    end
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; id_pc = 32'h304;
    step();
    checks++;
    if (ex_pc !== 32'h304 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL areset_release got pc=%h v=%b exp pc=304 v=1", ex_pc, ex_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_valid_gate();
    test_load_use();
    test_stall_hold();
    test_flush_priority();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
